// File: rtl/painterengine_gpu_dvi_capture.sv
// painterengine_gpu_dvi_capture
// Receive side of the GPU DVI link. Samples hs/vs/de/rgb on the pixel clock
// and captures one clipped frame as a packed RGBA pixel stream with x/y
// coordinates. It also measures the line width, the frame height and the
// hs period of the incoming video.
// Optional feature: define PAINTERENGINE_DVI_CAPTURE_CRC_EN to add o_wire_crc,
// a CRC-16/CCITT over the {R,G,B} of every emitted pixel.
module painterengine_gpu_dvi_capture #(
  parameter logic       HS_POL     = 1'b1,
  parameter logic       VS_POL     = 1'b1,
  parameter logic [7:0] ALPHA_FILL = 8'hFF
) (
  input  logic        i_wire_pixel_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_start,
  input  logic        i_wire_hs,
  input  logic        i_wire_vs,
  input  logic        i_wire_de,
  input  logic [23:0] i_wire_rgb,
  input  logic [2:0]  i_wire_rgba_mode,
  input  logic [15:0] i_wire_clip_width,
  input  logic [15:0] i_wire_clip_height,
  output logic        o_wire_pixel_valid,
  output logic [31:0] o_wire_rgba,
`ifdef PAINTERENGINE_DVI_CAPTURE_CRC_EN
  output logic [15:0] o_wire_crc,
`endif
  output logic [11:0] o_wire_x,
  output logic [11:0] o_wire_y,
  output logic        o_wire_sof,
  output logic        o_wire_busy,
  output logic        o_wire_done,
  output logic [31:0] o_wire_counter,
  output logic [11:0] o_wire_meas_width,
  output logic [11:0] o_wire_meas_height,
  output logic [15:0] o_wire_meas_htotal
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Input sample stage (s1) and its delayed copy (s2)
  logic        hs1_q, vs1_q, de1_q;
  logic [23:0] rgb1_q;
  logic        hs2_q, vs2_q, de2_q;

  logic        vs_edge_s, hs_edge_s, de_fall_s, emit_s;
  logic [11:0] cur_x_s;
  logic [31:0] clip_area_s;

  logic [11:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic [15:0] htcnt_q, htcnt_d, htlat_q, htlat_d;
  logic [11:0] wlat_q, wlat_d;

  logic [1:0]  state_q, state_d;
  logic        done_q, done_d, busy_q, busy_d;
  logic [31:0] counter_q, counter_d;
  logic [11:0] mw_q, mw_d, mh_q, mh_d;
  logic [15:0] mht_q, mht_d;

  logic        valid_q, valid_d, sof_q, sof_d;
  logic [31:0] rgba_q, rgba_d;
  logic [11:0] px_q, px_d, py_q, py_d;

  function automatic logic [31:0] pack_rgba(input logic [2:0] mode, input logic [23:0] rgb);
    logic [31:0] w;
    case (mode)
      3'd0:    w = {ALPHA_FILL, rgb[23:16], rgb[15:8], rgb[7:0]};
      3'd1:    w = {rgb[23:16], rgb[15:8], rgb[7:0], ALPHA_FILL};
      3'd2:    w = {ALPHA_FILL, rgb[7:0], rgb[15:8], rgb[23:16]};
      3'd3:    w = {rgb[7:0], rgb[15:8], rgb[23:16], ALPHA_FILL};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Register the video pins twice: s1 is the working sample, s2 feeds edge detection
  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de1_q  <= 1'b0;
      rgb1_q <= 24'd0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      de2_q  <= 1'b0;
    end else begin
      hs1_q  <= i_wire_hs;
      vs1_q  <= i_wire_vs;
      de1_q  <= i_wire_de;
      rgb1_q <= i_wire_rgb;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      de2_q  <= de1_q;
    end
  end

  // Edge detection and raster position of the s1 sample
  always_comb begin
    vs_edge_s   = (vs1_q == VS_POL) && (vs2_q != VS_POL);
    hs_edge_s   = (hs1_q == HS_POL) && (hs2_q != HS_POL);
    de_fall_s   = de2_q && !de1_q;
    clip_area_s = {16'd0, i_wire_clip_width} * {16'd0, i_wire_clip_height};
    if (de1_q && !de2_q) begin
      cur_x_s = 12'd0;
    end else begin
      cur_x_s = xcnt_q;
    end
    emit_s = (state_q == ST_CAPTURE) && !vs_edge_s && de1_q &&
             ({4'd0, cur_x_s} < i_wire_clip_width) &&
             ({4'd0, ycnt_q} < i_wire_clip_height) &&
             (counter_q < clip_area_s);
  end

  // Next values of the x/y raster counters and the timing measurement helpers
  always_comb begin
    if (de1_q) begin
      xcnt_d = cur_x_s + 12'd1;
    end else begin
      xcnt_d = xcnt_q;
    end
    if (vs_edge_s) begin
      ycnt_d = 12'd0;
    end else if (de_fall_s) begin
      ycnt_d = ycnt_q + 12'd1;
    end else begin
      ycnt_d = ycnt_q;
    end
    if (hs_edge_s) begin
      htcnt_d = 16'd0;
      htlat_d = htcnt_q + 16'd1;
    end else begin
      htcnt_d = htcnt_q + 16'd1;
      htlat_d = htlat_q;
    end
    if (de_fall_s) begin
      wlat_d = xcnt_q;
    end else begin
      wlat_d = wlat_q;
    end
  end

  // Capture FSM: arming, frame boundaries, pixel counter and measurement latch
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    counter_d = counter_q;
    mw_d      = mw_q;
    mh_d      = mh_q;
    mht_d     = mht_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_wire_start) begin
          state_d   = ST_WAIT_VS;
          done_d    = 1'b0;
          counter_d = 32'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_VS: begin
        if (vs_edge_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT_VS;
        end
      end
      ST_CAPTURE: begin
        if (vs_edge_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          // a line ending in the same cycle still counts towards the frame
          mw_d    = de_fall_s ? xcnt_q : wlat_q;
          mh_d    = ycnt_q + {11'd0, de_fall_s};
          mht_d   = htlat_q;
        end else if (emit_s) begin
          counter_d = counter_q + 32'd1;
        end else begin
          counter_d = counter_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_WAIT_VS) || (state_d == ST_CAPTURE);
  end

  // Output word for the next cycle; everything is zero when nothing is emitted
  always_comb begin
    valid_d = emit_s;
    if (emit_s) begin
      rgba_d = pack_rgba(i_wire_rgba_mode, rgb1_q);
      px_d   = cur_x_s;
      py_d   = ycnt_q;
      sof_d  = (counter_q == 32'd0);
    end else begin
      rgba_d = 32'd0;
      px_d   = 12'd0;
      py_d   = 12'd0;
      sof_d  = 1'b0;
    end
  end

  // State, counters, measurements and output registers
  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      xcnt_q    <= 12'd0;
      ycnt_q    <= 12'd0;
      htcnt_q   <= 16'd0;
      htlat_q   <= 16'd0;
      wlat_q    <= 12'd0;
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      counter_q <= 32'd0;
      mw_q      <= 12'd0;
      mh_q      <= 12'd0;
      mht_q     <= 16'd0;
      valid_q   <= 1'b0;
      rgba_q    <= 32'd0;
      px_q      <= 12'd0;
      py_q      <= 12'd0;
      sof_q     <= 1'b0;
    end else begin
      xcnt_q    <= xcnt_d;
      ycnt_q    <= ycnt_d;
      htcnt_q   <= htcnt_d;
      htlat_q   <= htlat_d;
      wlat_q    <= wlat_d;
      state_q   <= state_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      counter_q <= counter_d;
      mw_q      <= mw_d;
      mh_q      <= mh_d;
      mht_q     <= mht_d;
      valid_q   <= valid_d;
      rgba_q    <= rgba_d;
      px_q      <= px_d;
      py_q      <= py_d;
      sof_q     <= sof_d;
    end
  end

`ifdef PAINTERENGINE_DVI_CAPTURE_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_rgb(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  // CRC seeds at the start of the captured frame and only moves on emitted pixels
  always_comb begin
    if ((state_q == ST_WAIT_VS) && vs_edge_s) begin
      crc_d = 16'hFFFF;
    end else if (emit_s) begin
      crc_d = crc16_rgb(crc_q, rgb1_q);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register
  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      crc_q <= 16'd0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_wire_crc = crc_q;
`endif

  assign o_wire_pixel_valid = valid_q;
  assign o_wire_rgba        = rgba_q;
  assign o_wire_x           = px_q;
  assign o_wire_y           = py_q;
  assign o_wire_sof         = sof_q;
  assign o_wire_busy        = busy_q;
  assign o_wire_done        = done_q;
  assign o_wire_counter     = counter_q;
  assign o_wire_meas_width  = mw_q;
  assign o_wire_meas_height = mh_q;
  assign o_wire_meas_htotal = mht_q;

endmodule

// File: tb/tb_painterengine_gpu_dvi_capture.sv
// Self-checking bench for painterengine_gpu_dvi_capture.
// Drives an 8x4 active raster (htotal 14, 7 lines per frame) and predicts
// the captured pixel stream frame by frame from the capture rules.
module tb_painterengine_gpu_dvi_capture;
  localparam int H_ACT = 8, H_TOT = 14, V_ACT = 4, V_TOT = 7, VS_LINE = 5;

  logic        clk = 1'b0;
  logic        resetn, start, hs, vs, de;
  logic [23:0] rgb;
  logic [2:0]  mode;
  logic [15:0] cw, ch;
  logic        valid, sof, busy, done;
  logic [31:0] rgba, counter;
  logic [11:0] ox, oy, mw, mh;
  logic [15:0] mht;

  painterengine_gpu_dvi_capture dut (
    .i_wire_pixel_clock(clk), .i_wire_resetn(resetn), .i_wire_start(start),
    .i_wire_hs(hs), .i_wire_vs(vs), .i_wire_de(de), .i_wire_rgb(rgb),
    .i_wire_rgba_mode(mode), .i_wire_clip_width(cw), .i_wire_clip_height(ch),
    .o_wire_pixel_valid(valid), .o_wire_rgba(rgba), .o_wire_x(ox), .o_wire_y(oy),
    .o_wire_sof(sof), .o_wire_busy(busy), .o_wire_done(done), .o_wire_counter(counter),
    .o_wire_meas_width(mw), .o_wire_meas_height(mh), .o_wire_meas_htotal(mht)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] rgba;
    logic [11:0] x, y;
    logic        sof;
  } exp_t;
  exp_t q[$];

  // model of the capture: 0 idle, 1 armed, 2 capturing, 3 finished
  int          m_st = 0, m_count = 0, m_mw = 0, m_mh = 0, m_mht = 0;
  bit          m_done = 1'b0;
  int          n_seen = 0;
  logic [31:0] sof_rgba = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_pack(input logic [2:0] m, input logic [23:0] p);
    logic [7:0] r, g, b;
    {r, g, b} = p;
    case (m)
      3'd0:    return {8'hFF, r, g, b};
      3'd1:    return {r, g, b, 8'hFF};
      3'd2:    return {8'hFF, b, g, r};
      3'd3:    return {b, g, r, 8'hFF};
      default: return 32'd0;
    endcase
  endfunction

  // compare process: every cycle the output is either the predicted pixel or all zero
  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          chk("pixel_due", 64'(cyc), 64'(q[0].due));
          q.delete(0);
        end
        if (valid === 1'b1) begin
          n_seen++;
          if (sof === 1'b1) sof_rgba = rgba;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("valid", 64'(valid), 64'd1);
          chk("rgba", 64'(rgba), 64'(e.rgba));
          chk("x", 64'(ox), 64'(e.x));
          chk("y", 64'(oy), 64'(e.y));
          chk("sof", 64'(sof), 64'(e.sof));
        end else begin
          chk("idle_valid", 64'(valid), 64'd0);
          chk("idle_word", {rgba, ox, oy, 7'd0, sof}, 64'd0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_word"}, {rgba, ox, oy, 7'd0, sof}, 64'd0);
    chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_counter"}, 64'(counter), 64'd0);
    chk({tag, "_meas"}, {24'd0, mw, mh, mht}, 64'd0);
  endtask

  // one video frame; slot = line*H_TOT + column, -1 disables a hook
  // pixmode: 0 = {y,x,5A}, 1 = 0x112233, 2 = random
  task automatic run_frame(input int start_at, input int start2_at, input int reset_at,
                           input int pixmode);
    int          slot;
    logic [23:0] pix;
    exp_t        e;
    for (int ln = 0; ln < V_TOT; ln++) begin
      for (int s = 0; s < H_TOT; s++) begin
        slot = ln * H_TOT + s;
        @(posedge clk);
        #2;
        case (pixmode)
          0:       pix = {8'(ln), 8'(s), 8'h5A};
          1:       pix = 24'h112233;
          default: pix = 24'($urandom);
        endcase
        de    = (ln < V_ACT) && (s < H_ACT);
        hs    = (s == 10) || (s == 11);
        vs    = (ln == VS_LINE);
        rgb   = pix;
        start = (slot == start_at) || (slot == start2_at);
        if (start && (m_st == 0 || m_st == 3)) begin
          m_st = 1; m_done = 1'b0; m_count = 0;
        end
        if (vs && s == 0) begin
          if (m_st == 1) m_st = 2;
          else if (m_st == 2) begin
            m_st = 3; m_done = 1'b1; m_mw = H_ACT; m_mh = V_ACT; m_mht = H_TOT;
          end
        end
        if (de && m_st == 2 && s < int'(cw) && ln < int'(ch)) begin
          e.due = cyc + 2; e.rgba = model_pack(mode, pix);
          e.x = 12'(s); e.y = 12'(ln); e.sof = (m_count == 0);
          q.push_back(e);
          m_count++;
        end
        if (slot == reset_at) begin
          resetn = 1'b0;
          m_st = 0; m_done = 1'b0; m_count = 0; m_mw = 0; m_mh = 0; m_mht = 0;
          q.delete();
          #1;
          check_all_zero("reset_mid");
        end
        if (slot == reset_at + 3) resetn = 1'b1;
        if (s == 12) begin
          chk("busy", 64'(busy), 64'(m_st == 1 || m_st == 2));
          chk("done", 64'(done), 64'(m_done));
          chk("counter", 64'(counter), 64'(m_count));
          chk("meas", {24'd0, mw, mh, mht}, {24'd0, 12'(m_mw), 12'(m_mh), 16'(m_mht)});
        end
      end
    end
  endtask

  logic [31:0] pack_exp [5] = '{32'hFF112233, 32'h112233FF, 32'hFF332211, 32'h332211FF, 32'h0};
  logic [2:0]  pack_mode[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

  initial begin : stim
    resetn = 1'b0; start = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; rgb = 24'd0;
    mode = 3'd0; cw = 16'd8; ch = 16'd4;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset_init");
    resetn = 1'b1;
    chk_en = 1'b1;

    // basic capture, start early in the first frame
    n_seen = 0;
    run_frame(2, -1, -1, 0);
    run_frame(-1, -1, -1, 0);
    chk("basic_npix", 64'(n_seen), 64'd32);
    chk("basic_sof_rgba", 64'(sof_rgba), 64'hFF00005A);
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_counter", 64'(counter), 64'd32);
    chk("basic_meas", {24'd0, mw, mh, mht}, {24'd0, 12'd8, 12'd4, 16'd14});

    // clipping 5x2, armed from the finished state
    cw = 16'd5; ch = 16'd2; n_seen = 0;
    run_frame(3, -1, -1, 0);
    chk("clip_done_cleared", 64'(done), 64'd0);
    run_frame(-1, -1, -1, 0);
    chk("clip_npix", 64'(n_seen), 64'd10);
    chk("clip_counter", 64'(counter), 64'd10);
    chk("clip_done", 64'(done), 64'd1);

    // packing modes
    cw = 16'd8; ch = 16'd4;
    for (int i = 0; i < 5; i++) begin
      mode = pack_mode[i]; sof_rgba = 32'hDEADBEEF;
      run_frame(1, -1, -1, 1);
      run_frame(-1, -1, -1, 1);
      chk("pack_sof_rgba", 64'(sof_rgba), 64'(pack_exp[i]));
    end

    // arming mid-frame, second start while capturing is ignored
    mode = 3'd0; n_seen = 0;
    run_frame(2 * H_TOT + 4, -1, -1, 0);
    chk("arm_no_early_pix", 64'(n_seen), 64'd0);
    run_frame(-1, 2 * H_TOT + 3, -1, 0);
    chk("arm_npix", 64'(n_seen), 64'd32);
    chk("arm_counter", 64'(counter), 64'd32);
    n_seen = 0;
    run_frame(1, -1, -1, 0);
    run_frame(-1, -1, -1, 0);
    chk("rearm_npix", 64'(n_seen), 64'd32);
    chk("rearm_done", 64'(done), 64'd1);

    // reset at pixel 15 of a captured frame, then a frame without start
    run_frame(0, -1, -1, 0);
    n_seen = 0;
    run_frame(-1, -1, H_TOT + 7, 0);
    chk("reset_npix", 64'(n_seen), 64'd13);
    run_frame(-1, -1, -1, 0);
    chk("reset_no_more_pix", 64'(n_seen), 64'd13);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_counter", 64'(counter), 64'd0);

    // randomized captures: mode, clip, pixel data and start positions
    for (int it = 0; it < 10; it++) begin
      mode = 3'($urandom_range(7, 0));
      cw   = 16'($urandom_range(9, 0));
      ch   = 16'($urandom_range(5, 0));
      run_frame(int'($urandom_range(3, 0)) * H_TOT + int'($urandom_range(7, 0)), -1, -1, 2);
      run_frame(-1, ($urandom_range(1, 0) == 1) ?
                int'($urandom_range(3, 0)) * H_TOT + int'($urandom_range(7, 0)) : -1, -1, 2);
      chk("rand_done", 64'(done), 64'd1);
      chk("rand_counter", 64'(counter), 64'((cw > 16'd8 ? 8 : int'(cw)) * (ch > 16'd4 ? 4 : int'(ch))));
    end

    repeat (4) @(posedge clk);
    #2;
    chk("drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/painterengine_gpu_dvi_capture.md
Name: painterengine_gpu_dvi_capture

Overview:
Receive-side counterpart of the GPU DVI timing generator. Samples a parallel RGB video stream (hs/vs/de/rgb24) on the pixel clock. Captures exactly one clipped frame into a pixel stream with x/y coordinates, packed in the selected RGBA layout. Measures the incoming line and frame timing for software readback.

Parameters:
- HS_POL, 1'b1, active level of i_wire_hs.
- VS_POL, 1'b1, active level of i_wire_vs.
- ALPHA_FILL, 8'hFF, alpha byte inserted into the packed output word.

Ports:
- i_wire_pixel_clock  in  1  pixel clock; all logic on its rising edge.
- i_wire_resetn  in  1  asynchronous, active-low reset.
- i_wire_start  in  1  single-cycle pulse that arms a one-frame capture.
- i_wire_hs  in  1  horizontal sync.
- i_wire_vs  in  1  vertical sync.
- i_wire_de  in  1  data enable.
- i_wire_rgb  in  24  {R,G,B}.
- i_wire_rgba_mode  in  3  0=ARGB, 1=RGBA, 2=ABGR, 3=BGRA; other values give a zero word.
- i_wire_clip_width  in  16  pixels per line to emit.
- i_wire_clip_height  in  16  lines to emit.
- o_wire_pixel_valid  out  1  o_wire_rgba, o_wire_x and o_wire_y are valid this cycle.
- o_wire_rgba  out  32  packed pixel.
- o_wire_x  out  12  column of the emitted pixel.
- o_wire_y  out  12  row of the emitted pixel.
- o_wire_sof  out  1  with valid, marks the first emitted pixel (0,0).
- o_wire_busy  out  1  FSM is in WAIT_VS or CAPTURE.
- o_wire_done  out  1  sticky; a frame has been captured.
- o_wire_counter  out  32  pixels emitted in the current or last capture.
- o_wire_meas_width  out  12  de-high length of the last active line.
- o_wire_meas_height  out  12  number of de lines in the captured frame.
- o_wire_meas_htotal  out  16  clocks between consecutive hs active edges.

Behaviour:
- Input stage: hs/vs/de/rgb registered once (s1), plus a one-cycle-delayed copy (s2) for edge detection.
- vs_edge = (s1.vs==VS_POL && s2.vs!=VS_POL). hs_edge is defined the same way with HS_POL. de_fall = s2.de && !s1.de.
- x counter: 0 on the first de cycle of a line, +1 per de cycle, held while de is low.
- y counter: 0 on vs_edge, +1 on each de_fall. Both counters wrap at 4095.
- htotal counter: +1 every clock; on hs_edge its value+1 is latched into an internal register and the counter clears.
- FSM states: IDLE, WAIT_VS, CAPTURE, DONE. Reset state is IDLE.
  - IDLE/DONE + start -> WAIT_VS; clears o_wire_done and o_wire_counter.
  - WAIT_VS + vs_edge -> CAPTURE; y counter resets to 0.
  - CAPTURE + vs_edge -> DONE; o_wire_done=1; meas_width, meas_height and meas_htotal are latched from the finished frame.
  - start in WAIT_VS or CAPTURE is ignored.
- Emission (CAPTURE only), when s1.de && x<clip_width && y<clip_height && counter<clip_width*clip_height (32-bit product):
  - next cycle: valid=1, rgba packed per mode, x/y = coordinates of that sample, counter +1.
  - Pin-to-output latency is 2 clocks.
- Packing with A=ALPHA_FILL:
  - ARGB = {A,R,G,B}
  - RGBA = {R,G,B,A}
  - ABGR = {A,B,G,R}
  - BGRA = {B,G,R,A}
- When valid=0: rgba, x, y and sof are driven 0.
- Clip width or height of 0: no pixels emitted; DONE is still reached on the next vs_edge.
- vs_edge in the same cycle as de: vs_edge wins; that sample is not emitted in CAPTURE.
- Reset (any time, including mid-frame): all outputs are 0, FSM returns to IDLE, all counters and measurement registers are 0.

Optional Feature:
- Macro PAINTERENGINE_DVI_CAPTURE_CRC_EN.
- When defined: adds output o_wire_crc[15:0], a CRC-16/CCITT (poly 0x1021, init 0xFFFF) over the 24-bit {R,G,B} of every emitted pixel, MSB first. It is reset to 0xFFFF on the WAIT_VS->CAPTURE transition and frozen in DONE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench stimulus format: 8x4 active, hfp/hs/hbp=2/2/2 (htotal 14), vfp/vs/vbp=1/1/1, pixel value = {y,x,8'h5A}, mode ARGB, clip 8x4, start pulse.
- Basic capture: above stimulus -> 32 valid pixels in raster order; first pixel has sof=1 with rgba 0xFF00005A; done=1 after the next vs_edge; counter=32; meas_width=8, meas_height=4, meas_htotal=14.
- Clipping: clip 5x2 -> exactly 10 pixels, x 0..4, y 0..1; counter=10; done still asserted at the next vs_edge.
- Packing: single capture per mode 0..3 with pixel 0x112233 -> 0xFF112233, 0x112233FF, 0xFF332211, 0x332211FF; mode 5 -> 0x00000000.
- Arming: start mid-frame -> no output until the following vs_edge; a second start while busy -> ignored; start in DONE -> done clears and a fresh capture occurs.
- Reset: assert resetn=0 at pixel 15 -> all outputs 0 and state IDLE; no pixels emitted after release until a new start is issued.
